fetch_stage: RTL and testbench

- Instruction-fetch front end: owns the PC register, issues requests to instruction memory, and holds the IF/ID pipeline register.
- Consumes the hazard unit's redirect/flush outputs (PcRst, PcRstAddr, IfIdRst) and the decode-side Stall.
- Tolerates variable instruction-memory latency and discards any fetch that is killed while in flight.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 33 +++
 rtl/if_id_reg.sv | 69 ++++++
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
//
// Provides the fetch FSM state type, default address/instruction widths, the
// NOP encoding written into pipeline registers on flush, and a helper that
// tells whether a state keeps an instruction-memory request outstanding.
package fetch_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int INST_W_DEF = 16;

    localparam logic [INST_W_DEF-1:0] NOP_INS = '0;

    // FETCH: normal request/accept flow
    // DRAIN: waiting out a request that was killed by a redirect
    // HOLD : one fetched word parked in the skid because decode stalled
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic is_req_state(input fetch_state_t s);
        return (s == FETCH) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/acknowledge bundle
//
// Signals:
//   IMemReq  : fetch request, held until IMemAck
//   IMemAddr : fetch address, stable while the request is outstanding
//   IMemAck  : data valid this cycle, completes the request
//   IMemData : fetched instruction word
// Modports:
//   master : fetch side (drives request/address)
//   slave  : memory side (drives acknowledge/data)
interface fetch_stage_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16
);
    logic              IMemReq;
    logic [ADDR_W-1:0] IMemAddr;
    logic              IMemAck;
    logic [INST_W-1:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - generic pipeline register with flush, hold and load
//
// Update priority: flush > hold > load. With none of them asserted the
// downstream stage has consumed the entry, so it becomes a bubble.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : clear entry (valid=0, pc=0, ins=NOP)
//   hold              : keep current entry
//   load, in_pc, in_ins : write a live entry
//   valid, pc, ins    : registered entry
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              load,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_ins,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] ins
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] ins_q, ins_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            ins_d   = INST_W'(NOP_INS);
        end else if (hold) begin
            valid_d = valid_q;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            ins_d   = in_ins;
        end else begin
            // Entry consumed with nothing new behind it; keep data, kill valid.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ins_q   <= INST_W'(NOP_INS);
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign ins   = ins_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch front end: PC, imem requests, IF/ID register
//
// Optional build macro: FETCH_PERF_CNT_EN adds KillCnt/StallCnt counters.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   PcRst, PcRstAddr    : redirect request and target from the hazard unit
//   IfIdRst             : flush IF/ID
//   Stall               : decode cannot accept, hold IF/ID
//   imem                : instruction-memory request/ack bundle (master side)
//   IfIdValid/Pc/Ins    : IF/ID pipeline register contents
//   KillCnt, StallCnt   : saturating event counters (FETCH_PERF_CNT_EN only)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PcRst,
    input  logic [ADDR_W-1:0] PcRstAddr,
    input  logic              IfIdRst,
    input  logic              Stall,
    fetch_stage_if.master     imem,
    output logic              IfIdValid,
    output logic [ADDR_W-1:0] IfIdPc,
    output logic [INST_W-1:0] IfIdIns
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       KillCnt,
    output logic [15:0]       StallCnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_ins_q, skid_ins_d;

    logic              req;
    logic              ack;
    logic              ld;
    logic [ADDR_W-1:0] ld_pc;
    logic [INST_W-1:0] ld_ins;

    assign req = is_req_state(state_q);
    // An ack only means something while a request is outstanding.
    assign ack = imem.IMemAck && req;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        skid_pc_d  = skid_pc_q;
        skid_ins_d = skid_ins_q;
        ld         = 1'b0;
        ld_pc      = pc_q;
        ld_ins     = imem.IMemData;

        case (state_q)
            FETCH: begin
                if (ack) begin
                    if (PcRst) begin
                        pc_d = PcRstAddr;
                    end else if (!Stall) begin
                        ld   = 1'b1;
                        pc_d = pc_q + ADDR_W'(1);
                    end else begin
                        // Decode is stalled: park the word so memory is not re-asked.
                        skid_pc_d  = pc_q;
                        skid_ins_d = imem.IMemData;
                        pc_d       = pc_q + ADDR_W'(1);
                        state_d    = HOLD;
                    end
                end else if (PcRst) begin
                    // Cannot re-address an outstanding request; remember target.
                    pend_d  = PcRstAddr;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (PcRst) begin
                    pend_d = PcRstAddr;
                end
                if (ack) begin
                    pc_d    = PcRst ? PcRstAddr : pend_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (PcRst) begin
                    pc_d    = PcRstAddr;
                    state_d = FETCH;
                end else if (!Stall) begin
                    ld      = 1'b1;
                    ld_pc   = skid_pc_q;
                    ld_ins  = skid_ins_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            skid_pc_q  <= '0;
            skid_ins_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            skid_pc_q  <= skid_pc_d;
            skid_ins_q <= skid_ins_d;
        end
    end

    assign imem.IMemReq  = req && !rst;
    assign imem.IMemAddr = pc_q;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .flush  (IfIdRst),
        .hold   (Stall),
        .load   (ld),
        .in_pc  (ld_pc),
        .in_ins (ld_ins),
        .valid  (IfIdValid),
        .pc     (IfIdPc),
        .ins    (IfIdIns)
    );

`ifdef FETCH_PERF_CNT_EN
    logic        kill;
    logic [15:0] kill_cnt_q, kill_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // A fetched word is lost when a redirect discards it, when a skid entry
    // is dropped, or when it would have loaded IF/ID in a flush cycle.
    assign kill = ((state_q == FETCH) && ack && PcRst) ||
                  ((state_q == DRAIN) && ack) ||
                  ((state_q == HOLD) && PcRst) ||
                  (ld && IfIdRst);

    always_comb begin
        kill_cnt_d  = kill_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (kill && (kill_cnt_q != 16'hFFFF)) begin
            kill_cnt_d = kill_cnt_q + 16'd1;
        end
        if (Stall && IfIdValid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kill_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            kill_cnt_q  <= kill_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign KillCnt  = kill_cnt_q;
    assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [15:0] RPC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, PcRst, IfIdRst, Stall;
    logic [15:0] PcRstAddr;
    logic        IfIdValid;
    logic [15:0] IfIdPc, IfIdIns;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] KillCnt, StallCnt;
`endif

    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_W(16), .INST_W(16)) imem_if ();

    fetch_stage #(.ADDR_W(16), .INST_W(16), .RESET_PC(RPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .PcRst     (PcRst),
        .PcRstAddr (PcRstAddr),
        .IfIdRst   (IfIdRst),
        .Stall     (Stall),
        .imem      (imem_if),
        .IfIdValid (IfIdValid),
        .IfIdPc    (IfIdPc),
        .IfIdIns   (IfIdIns)
`ifdef FETCH_PERF_CNT_EN
        ,
        .KillCnt   (KillCnt),
        .StallCnt  (StallCnt)
`endif
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: next address to fetch, an in-flight request that has
    // been killed (with its redirect target), parked words, IF/ID contents.
    bit          model_live = 0;
    logic [15:0] m_pc;
    bit          m_dead;
    logic [15:0] m_dead_tgt;
    logic [31:0] m_skid[$];
    bit          m_v;
    logic [15:0] m_ifpc, m_ifins;

    // Memory model
    int          mem_cnt = 0;
    int          cur_lat = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    logic [15:0] salt = 16'h0000;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ salt;
    endfunction

    function automatic void model_step(input bit r, input bit pr, input logic [15:0] pa,
                                       input bit ir, input bit st, input bit ack,
                                       input logic [15:0] data);
        logic [31:0] ld;
        bit          have_ld;
        have_ld = 0;
        ld      = '0;
        if (r) begin
            m_pc   = RPC;
            m_dead = 0;
            m_skid.delete();
            m_v    = 0;
            m_ifpc = 16'h0;
            m_ifins = 16'h0;
            return;
        end
        if (m_skid.size() != 0) begin
            if (pr) begin
                m_skid.delete();
                m_pc = pa;
            end else if (!st) begin
                ld = m_skid.pop_front();
                have_ld = 1;
            end
        end else if (m_dead) begin
            if (pr) m_dead_tgt = pa;
            if (ack) begin
                m_pc   = m_dead_tgt;
                m_dead = 0;
            end
        end else if (ack) begin
            if (pr) begin
                m_pc = pa;
            end else begin
                if (!st) begin
                    ld = {m_pc, data};
                    have_ld = 1;
                end else begin
                    m_skid.push_back({m_pc, data});
                end
                m_pc = m_pc + 16'd1;
            end
        end else if (pr) begin
            m_dead     = 1;
            m_dead_tgt = pa;
        end
        if (ir) begin
            m_v = 0;
            m_ifpc = 16'h0;
            m_ifins = 16'h0;
        end else if (st) begin
            m_v = m_v;
        end else if (have_ld) begin
            m_v = 1;
            m_ifpc = ld[31:16];
            m_ifins = ld[15:0];
        end else begin
            m_v = 0;
        end
    endfunction

    task automatic cycle(input bit r, input bit pr, input logic [15:0] pa, input bit ir, input bit st);
        bit          req_seen, ack;
        logic [15:0] addr_seen, data;
        rst = r; PcRst = pr; PcRstAddr = pa; IfIdRst = ir; Stall = st;
        imem_if.IMemAck = 1'b0;
        #1;
        if (model_live) begin
            check("req", {31'b0, imem_if.IMemReq}, {31'b0, (!r && m_skid.size() == 0)});
            check("addr", {16'b0, imem_if.IMemAddr}, {16'b0, m_pc});
            check("valid", {31'b0, IfIdValid}, {31'b0, m_v});
            if (m_v) begin
                check("ifid_pc", {16'b0, IfIdPc}, {16'b0, m_ifpc});
                check("ifid_ins", {16'b0, IfIdIns}, {16'b0, m_ifins});
            end
        end
        req_seen  = imem_if.IMemReq;
        addr_seen = imem_if.IMemAddr;
        ack       = req_seen && (mem_cnt >= cur_lat);
        data      = ack ? mem_word(addr_seen) : 16'($urandom);
        imem_if.IMemAck  = ack;
        imem_if.IMemData = data;
        @(posedge clk);
        model_step(r, pr, pa, ir, st, ack, data);
        if (r) model_live = 1;
        if (r) begin
            mem_cnt = 0;
        end else if (req_seen) begin
            if (ack) begin
                mem_cnt = 0;
                cur_lat = $urandom_range(lat_max, lat_min);
            end else begin
                mem_cnt++;
            end
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 16'h0, 0, 0);
    endtask

    task automatic set_lat(input int l);
        lat_min = l; lat_max = l; cur_lat = l;
    endtask

    initial begin
        bit          r, pr, ir, st;
        logic [15:0] pa;
        rst = 1; PcRst = 0; PcRstAddr = 0; IfIdRst = 0; Stall = 0;
        imem_if.IMemAck = 0; imem_if.IMemData = 0;
        set_lat(0);

        // Reset state
        cycle(1, 0, 16'h0, 0, 0);
        cycle(1, 0, 16'h0, 0, 0);
        check("rst_req", {31'b0, imem_if.IMemReq}, 32'd0);
        check("rst_valid", {31'b0, IfIdValid}, 32'd0);
        check("rst_pc", {16'b0, IfIdPc}, 32'd0);
        check("rst_ins", {16'b0, IfIdIns}, 32'd0);
        check("rst_addr", {16'b0, imem_if.IMemAddr}, 32'h0000);

        // Zero-wait streaming, data = address
        for (int i = 0; i < 4; i++) begin
            idle();
            check("t1_addr", {16'b0, imem_if.IMemAddr}, i + 1);
            check("t1_valid", {31'b0, IfIdValid}, 32'd1);
            check("t1_pc", {16'b0, IfIdPc}, i);
            check("t1_ins", {16'b0, IfIdIns}, i);
        end

        // Stall on the ack of pc 5
        idle();
        check("t2_pc4", {16'b0, IfIdPc}, 32'd4);
        cycle(0, 0, 16'h0, 0, 1);
        check("t2_hold_pc", {16'b0, IfIdPc}, 32'd4);
        check("t2_req_low", {31'b0, imem_if.IMemReq}, 32'd0);
        idle();
        check("t2_pc5", {16'b0, IfIdPc}, 32'd5);
        check("t2_addr6", {16'b0, imem_if.IMemAddr}, 32'd6);

        // Redirect + flush on the ack of pc 7
        idle();
        check("t3_addr7", {16'b0, imem_if.IMemAddr}, 32'd7);
        cycle(0, 1, 16'h0040, 1, 0);
        check("t3_valid", {31'b0, IfIdValid}, 32'd0);
        check("t3_addr", {16'b0, imem_if.IMemAddr}, 32'h0040);
        idle();
        check("t3_pc40", {16'b0, IfIdPc}, 32'h0040);

        // 3-cycle latency with two redirects while waiting on pc 0x10
        cycle(0, 1, 16'h0010, 1, 0);
        set_lat(3);
        cycle(0, 1, 16'h0100, 0, 0);
        check("t4_addr_a", {16'b0, imem_if.IMemAddr}, 32'h0010);
        cycle(0, 1, 16'h0200, 0, 0);
        check("t4_addr_b", {16'b0, imem_if.IMemAddr}, 32'h0010);
        idle();
        check("t4_addr_c", {16'b0, imem_if.IMemAddr}, 32'h0010);
        idle();
        check("t4_addr_new", {16'b0, imem_if.IMemAddr}, 32'h0200);
        check("t4_valid", {31'b0, IfIdValid}, 32'd0);

        // PC wrap
        set_lat(0);
        cycle(0, 1, 16'hFFFF, 1, 0);
        check("t5_addr_ffff", {16'b0, imem_if.IMemAddr}, 32'h0000FFFF);
        idle();
        check("t5_wrap", {16'b0, imem_if.IMemAddr}, 32'h0000);
        check("t5_pc", {16'b0, IfIdPc}, 32'h0000FFFF);

        // Reset while draining toward 0x300
        set_lat(3);
        cycle(0, 1, 16'h0300, 0, 0);
        cycle(1, 0, 16'h0, 0, 0);
        check("t6_req_rst", {31'b0, imem_if.IMemReq}, 32'd0);
        cycle(1, 0, 16'h0, 0, 0);
        set_lat(0);
        check("t6_addr", {16'b0, imem_if.IMemAddr}, {16'b0, RPC});
        check("t6_valid", {31'b0, IfIdValid}, 32'd0);
        idle();
        check("t6_pc", {16'b0, IfIdPc}, {16'b0, RPC});

        // Randomized traffic against the model
        lat_min = 0; lat_max = 3;
        salt = 16'($urandom);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(199, 0) == 0);
            pr = ($urandom_range(99, 0) < 8);
            pa = ($urandom_range(9, 0) == 0) ? 16'hFFFE : 16'($urandom);
            ir = pr ? ($urandom_range(3, 0) != 0) : ($urandom_range(29, 0) == 0);
            st = ($urandom_range(99, 0) < 30);
            cycle(r, pr, pa, ir, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
